// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: next-PC select encodings, fetch
// state encoding and the default reset PC.
package riscv_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_RSVD   = 2'b11
    } pcsrc_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_TRAP = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC adder and mux; flags any target that is not word aligned.
module pc_next_logic
    import riscv_pkg::*;
(
    input  logic [31:0] i_pc,
    input  pcsrc_e      i_pcsrc,
    input  logic [31:0] i_immext,
    input  logic [31:0] i_aluresult,
    output logic [31:0] o_next,
    output logic        o_misaligned
);

    logic [31:0] w_next;

    // Select the next PC; the reserved encoding falls back to sequential.
    always_comb begin
        w_next = i_pc + 32'd4;
        case (i_pcsrc)
            PC_PLUS4:  w_next = i_pc + 32'd4;
            PC_BRANCH: w_next = i_pc + i_immext;
            PC_JALR:   w_next = i_aluresult & 32'hFFFF_FFFE;
            default:   w_next = i_pc + 32'd4;
        endcase
    end

    assign o_next       = w_next;
    assign o_misaligned = !is_word_aligned(w_next[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time
// and holds the returned instruction for decode until it is accepted.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ_VALID,
    input  logic        IMEM_REQ_READY,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_RSP_VALID,
    input  logic [31:0] IMEM_RSP_DATA,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    input  logic [1:0]  PCSRC,
    input  logic [31:0] IMMEXT,
    input  logic [31:0] ALURESULT,
    output logic        MISALIGNED
);
    import riscv_pkg::*;

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_req_valid;
    logic         r_instr_valid;
    logic         r_misaligned;
    logic [31:0]  w_next_pc;
    logic         w_next_misaligned;
    logic         w_accept;
    logic         w_capture;

    pc_next_logic u_pc_next (
        .i_pc         (r_pc),
        .i_pcsrc      (pcsrc_e'(PCSRC)),
        .i_immext     (IMMEXT),
        .i_aluresult  (ALURESULT),
        .o_next       (w_next_pc),
        .o_misaligned (w_next_misaligned)
    );

    // Next-state decode; handshakes outside their own state are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (IMEM_REQ_READY) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (IMEM_RSP_VALID) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (INSTR_READY) begin
                    w_accept = 1'b1;
                    if (w_next_misaligned) begin
                        w_state_nxt = ST_TRAP;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_TRAP: w_state_nxt = ST_TRAP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register with output flags registered from the next state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= ST_IDLE;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_valid   <= (w_state_nxt == ST_REQ);
            r_instr_valid <= (w_state_nxt == ST_HOLD);
            r_misaligned  <= (w_state_nxt == ST_TRAP);
        end
    end

    // PC only advances on an accepted instruction with an aligned target.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc <= RESET_PC;
        end else if (w_accept && !w_next_misaligned) begin
            r_pc <= w_next_pc;
        end else begin
            r_pc <= r_pc;
        end
    end

    // Instruction word is captured only on the response that ends WAIT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_instr <= 32'h0000_0000;
        end else if (w_capture) begin
            r_instr <= IMEM_RSP_DATA;
        end else begin
            r_instr <= r_instr;
        end
    end

    assign IMEM_REQ_VALID = r_req_valid;
    assign IMEM_ADDR      = r_pc;
    assign INSTR_VALID    = r_instr_valid;
    assign INSTRUCTION    = r_instr;
    assign PC_OUT         = r_pc;
    assign MISALIGNED     = r_misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays instruction memory and
// decode, with expected addresses and words computed by hand.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        IMEM_REQ_VALID;
    logic        IMEM_REQ_READY = 1'b0;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RSP_VALID = 1'b0;
    logic [31:0] IMEM_RSP_DATA = 32'hDEAD_BEEF;
    logic        INSTR_VALID;
    logic        INSTR_READY = 1'b0;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC_OUT;
    logic [1:0]  PCSRC = 2'b00;
    logic [31:0] IMMEXT = 32'h0000_0000;
    logic [31:0] ALURESULT = 32'h0000_0000;
    logic        MISALIGNED;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit dut (
        .CLK            (CLK),
        .RST            (RST),
        .IMEM_REQ_VALID (IMEM_REQ_VALID),
        .IMEM_REQ_READY (IMEM_REQ_READY),
        .IMEM_ADDR      (IMEM_ADDR),
        .IMEM_RSP_VALID (IMEM_RSP_VALID),
        .IMEM_RSP_DATA  (IMEM_RSP_DATA),
        .INSTR_VALID    (INSTR_VALID),
        .INSTR_READY    (INSTR_READY),
        .INSTRUCTION    (INSTRUCTION),
        .PC_OUT         (PC_OUT),
        .PCSRC          (PCSRC),
        .IMMEXT         (IMMEXT),
        .ALURESULT      (ALURESULT),
        .MISALIGNED     (MISALIGNED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Serve one fetch: ready after rdy_lat cycles, response rsp_lat cycles after accept.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                         input int rdy_lat, input int rsp_lat);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (IMEM_REQ_VALID === 1'b1) seen = 1'b1;
            else @(negedge CLK);
        end
        chk("req_seen", {31'd0, seen}, 32'd1);
        chk("req_addr", IMEM_ADDR, exp_addr);
        for (int i = 0; i < rdy_lat; i++) begin
            @(negedge CLK);
            chk("req_hold_valid", {31'd0, IMEM_REQ_VALID}, 32'd1);
            chk("req_hold_addr", IMEM_ADDR, exp_addr);
        end
        IMEM_REQ_READY = 1'b1;
        @(negedge CLK);
        IMEM_REQ_READY = 1'b0;
        chk("req_drop", {31'd0, IMEM_REQ_VALID}, 32'd0);
        for (int i = 1; i < rsp_lat; i++) begin
            @(negedge CLK);
            chk("wait_no_req", {31'd0, IMEM_REQ_VALID}, 32'd0);
            chk("wait_no_valid", {31'd0, INSTR_VALID}, 32'd0);
        end
        IMEM_RSP_VALID = 1'b1;
        IMEM_RSP_DATA  = data;
        @(negedge CLK);
        IMEM_RSP_VALID = 1'b0;
        IMEM_RSP_DATA  = 32'hDEAD_BEEF;
        chk("hold_valid", {31'd0, INSTR_VALID}, 32'd1);
        chk("hold_instr", INSTRUCTION, data);
        chk("hold_pc", PC_OUT, exp_addr);
    endtask

    // Decode stalls for hold cycles, then accepts with the given next-PC controls.
    task automatic accept(input logic [31:0] exp_instr, input logic [31:0] exp_pc,
                          input logic [1:0] src, input logic [31:0] imm,
                          input logic [31:0] alu, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("stall_valid", {31'd0, INSTR_VALID}, 32'd1);
            chk("stall_instr", INSTRUCTION, exp_instr);
            chk("stall_pc", PC_OUT, exp_pc);
            chk("stall_no_req", {31'd0, IMEM_REQ_VALID}, 32'd0);
        end
        PCSRC       = src;
        IMMEXT      = imm;
        ALURESULT   = alu;
        INSTR_READY = 1'b1;
        @(negedge CLK);
        INSTR_READY = 1'b0;
        PCSRC       = 2'b01;
        IMMEXT      = 32'h5555_5555;
        ALURESULT   = 32'hAAAA_AAAB;
        chk("one_accept", {31'd0, INSTR_VALID}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_req_valid", {31'd0, IMEM_REQ_VALID}, 32'd0);
        chk("rst_instr_valid", {31'd0, INSTR_VALID}, 32'd0);
        chk("rst_instr", INSTRUCTION, 32'h0000_0000);
        chk("rst_pc", PC_OUT, 32'h0000_0000);
        chk("rst_misaligned", {31'd0, MISALIGNED}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("first_req_latency", {31'd0, IMEM_REQ_VALID}, 32'd1);

        // Sequential step from reset PC.
        fetch(32'h0000_0000, 32'h0050_0093, 0, 1);
        accept(32'h0050_0093, 32'h0000_0000, 2'b00, 32'h0, 32'h0, 0);
        // Branch forward to 0x100.
        fetch(32'h0000_0004, 32'h0000_0013, 0, 1);
        accept(32'h0000_0013, 32'h0000_0004, 2'b01, 32'h0000_00FC, 32'h0, 0);
        // Negative immediate: 0x100 - 16.
        fetch(32'h0000_0100, 32'h1111_1111, 0, 1);
        accept(32'h1111_1111, 32'h0000_0100, 2'b01, 32'hFFFF_FFF0, 32'h0, 0);
        fetch(32'h0000_00F0, 32'h2222_2222, 0, 1);
        accept(32'h2222_2222, 32'h0000_00F0, 2'b01, 32'h0000_0010, 32'h0, 0);
        // Positive immediate from 0x100.
        fetch(32'h0000_0100, 32'h3333_3333, 0, 1);
        accept(32'h3333_3333, 32'h0000_0100, 2'b01, 32'h0000_0008, 32'h0, 0);
        // JALR clears bit 0 of the ALU result.
        fetch(32'h0000_0108, 32'h4444_4444, 0, 1);
        accept(32'h4444_4444, 32'h0000_0108, 2'b10, 32'h0, 32'h0000_2005, 0);
        chk("jalr_no_trap", {31'd0, MISALIGNED}, 32'd0);
        // Backpressure on every handshake, then jump to the top of memory.
        fetch(32'h0000_2004, 32'h5A5A_5A5A, 3, 5);
        accept(32'h5A5A_5A5A, 32'h0000_2004, 2'b01, 32'hFFFF_DFF8, 32'h0, 4);
        // Wrap with reserved select; spurious response in HOLD is ignored.
        fetch(32'hFFFF_FFFC, 32'h6666_6666, 0, 1);
        IMEM_RSP_VALID = 1'b1;
        IMEM_RSP_DATA  = 32'h1234_5678;
        @(negedge CLK);
        IMEM_RSP_VALID = 1'b0;
        IMEM_RSP_DATA  = 32'hDEAD_BEEF;
        chk("spurious_rsp_ignored", INSTRUCTION, 32'h6666_6666);
        accept(32'h6666_6666, 32'hFFFF_FFFC, 2'b11, 32'h0000_0040, 32'h0, 0);

        // Reset while waiting for the response.
        chk("wrap_addr", IMEM_ADDR, 32'h0000_0000);
        IMEM_REQ_READY = 1'b1;
        @(negedge CLK);
        IMEM_REQ_READY = 1'b0;
        #2 RST = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, IMEM_REQ_VALID}, 32'd0);
        chk("async_rst_valid", {31'd0, INSTR_VALID}, 32'd0);
        chk("async_rst_instr", INSTRUCTION, 32'h0000_0000);
        @(negedge CLK);
        RST = 1'b1;
        IMEM_RSP_VALID = 1'b1;
        IMEM_RSP_DATA  = 32'hBAD0_BAD0;
        @(negedge CLK);
        IMEM_RSP_VALID = 1'b0;
        IMEM_RSP_DATA  = 32'hDEAD_BEEF;
        chk("post_rst_req", {31'd0, IMEM_REQ_VALID}, 32'd1);
        chk("post_rst_instr", INSTRUCTION, 32'h0000_0000);
        fetch(32'h0000_0000, 32'h7777_7777, 0, 2);

        // Misaligned branch target traps and stops fetching.
        accept(32'h7777_7777, 32'h0000_0000, 2'b01, 32'h0000_0006, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("trap_misaligned", {31'd0, MISALIGNED}, 32'd1);
            chk("trap_no_req", {31'd0, IMEM_REQ_VALID}, 32'd0);
            chk("trap_no_valid", {31'd0, INSTR_VALID}, 32'd0);
            chk("trap_pc_kept", IMEM_ADDR, 32'h0000_0000);
            IMEM_REQ_READY = 1'b1;
            @(negedge CLK);
        end
        IMEM_REQ_READY = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
